// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: default widths, reset PC and queue entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One queued fetch: instruction word and the address of the next sequential word.
  // The queue stores entries packed in this order, instr in the upper half.
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] instr;
    logic [XLEN_DEFAULT-1:0] pcplus4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular entry store with wrapping read/write pointers and an occupancy count.
// Latency: a pushed entry is readable at rd_dat the cycle after the push.
// Backpressure: caller must not push when full unless it pops in the same cycle.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_dat,
  output logic [WIDTH-1:0]         rd_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign rd_dat = mem[rd_ptr];
  assign full   = (count == (AW+1)'(DEPTH));

  // Entry storage needs no reset; only pointers and count define validity.
  // When full, push+pop overwrite the slot being popped, which is safe.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: PC sequencing, redirect handling and a queue toward decode.
// Latency: one cycle ROM-to-decode; zero cycles when FETCH_QUEUE_BYPASS_EN is defined and the queue is empty.
// Backpressure: out_ready low holds the head; fetch stalls once the queue is full.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-3:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pcplus4,
  output logic            misalign_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = 2 * XLEN;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pc_plus4;
  logic [CW-1:0]   count;
  logic            full;
  logic            q_valid;
  logic            pop;
  logic            push;
  logic            bypass;
  logic [EW-1:0]   head;

  assign pc_plus4  = fetch_pc + XLEN'(4);
  assign imem_addr = fetch_pc[XLEN-1:2];
  assign q_valid   = (count != '0);

  // A redirect squashes both the dequeue and the fetch of this cycle.
  assign pop = q_valid && out_ready && !redirect_valid && !rst;

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue and a ready decoder: hand the ROM word straight through.
  assign bypass = !q_valid && out_ready && !redirect_valid && !rst;
`else
  assign bypass = 1'b0;
`endif

  // Fetch whenever there is room, counting the slot freed by a same-cycle pop.
  assign push = !rst && !redirect_valid && !bypass && (!full || pop);

  assign out_valid   = q_valid || bypass;
  assign out_instr   = bypass ? imem_rdata : head[EW-1:XLEN];
  assign out_pcplus4 = bypass ? pc_plus4   : head[XLEN-1:0];

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush  (redirect_valid),
    .push   (push),
    .pop    (pop),
    .wr_dat ({imem_rdata, pc_plus4}),
    .rd_dat (head),
    .count  (count),
    .full   (full)
  );

  // Fetch PC: reset, then redirect (forced word-aligned), then sequential advance.
  always_ff @(posedge clk) begin
    if (rst)                 fetch_pc <= RESET_PC;
    else if (redirect_valid) fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
    else if (push || bypass) fetch_pc <= pc_plus4;
  end

  // Misaligned redirect target flagged for exactly the following cycle.
  always_ff @(posedge clk) begin
    if (rst) misalign_err <= 1'b0;
    else     misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_ready = 1'b0;
  logic [29:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pcplus4;
  logic        misalign_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // ROM: word n holds 0x1000_0000 + n.
  assign imem_rdata = 32'h1000_0000 + {2'b00, imem_addr};

  fetch_queue #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RPC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pcplus4    (out_pcplus4),
    .misalign_err   (misalign_err)
  );

  // Reference model: a queue of expected entries plus the architectural fetch PC.
  fetch_entry_t exp_q[$];
  fetch_entry_t e;
  logic [31:0]  m_pc  = 32'h0;
  logic         m_mis = 1'b0;
  bit           m_live = 0;
  bit           m_pop, m_byp;
  int           m_sz;

  function automatic logic [31:0] rom(input logic [31:0] pc);
    return 32'h1000_0000 + (pc >> 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: inputs are stable at the falling edge; compare, then advance the model
  // to what the coming rising edge should produce.
  always @(negedge clk) begin
    if (m_live) begin
      m_sz  = exp_q.size();
      m_byp = 0;
`ifdef FETCH_QUEUE_BYPASS_EN
      m_byp = !rst && (m_sz == 0) && !redirect_valid && out_ready;
`endif
      m_pop = !rst && (m_sz != 0) && out_ready && !redirect_valid;
      chk("out_valid", 32'(out_valid), 32'((m_sz != 0) || m_byp));
      chk("imem_addr", 32'(imem_addr), m_pc >> 2);
      chk("misalign_err", 32'(misalign_err), 32'(m_mis));
      if (m_pop) begin
        e = exp_q.pop_front();
        chk("out_instr", out_instr, e.instr);
        chk("out_pcplus4", out_pcplus4, e.pcplus4);
      end else if (m_byp) begin
        chk("bypass_instr", out_instr, rom(m_pc));
        chk("bypass_pcplus4", out_pcplus4, m_pc + 32'd4);
      end
    end else begin
      m_sz = 0; m_pop = 0; m_byp = 0;
    end

    if (rst) begin
      exp_q.delete();
      m_pc   = RPC;
      m_mis  = 1'b0;
      m_live = 1;
    end else if (m_live) begin
      m_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) begin
        exp_q.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
      end else if (m_byp) begin
        m_pc = m_pc + 32'd4;
      end else if ((m_sz < DEPTH) || m_pop) begin
        exp_q.push_back('{instr: rom(m_pc), pcplus4: m_pc + 32'd4});
        m_pc = m_pc + 32'd4;
      end
    end
  end

  task automatic cyc(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
    @(posedge clk);
    #1;
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rp;
    out_ready      = rdy;
  endtask

  initial begin
    logic [31:0] rp;
    // Reset, then free-running fetch.
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    repeat (12) cyc(0, 0, 0, 1);
    // Stall decode long enough to fill the queue, then drain.
    repeat (10) cyc(0, 0, 0, 0);
    repeat (10) cyc(0, 0, 0, 1);
    // Flush, build count=3, then redirect to 0x40.
    cyc(0, 1, 32'h0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 1, 32'h0000_0040, 1);
    repeat (6) cyc(0, 0, 0, 1);
    // Misaligned redirect.
    cyc(0, 1, 32'h0000_0042, 1);
    repeat (6) cyc(0, 0, 0, 1);
    // Mid-stream reset with two entries queued.
    cyc(0, 1, 32'h0000_0100, 0);
    repeat (2) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 1);
    repeat (6) cyc(0, 0, 0, 1);
    // PC wrap past the top of the address space.
    cyc(0, 1, 32'hFFFF_FFF4, 1);
    repeat (8) cyc(0, 0, 0, 1);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rp = $urandom;
      if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 15) == 0),
          rp,
          ($urandom_range(0, 9) < 7));
    end
    cyc(0, 0, 0, 1);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath, PC and instruction width.
REQ-002 SHALL have parameter DEPTH, default 4: queue entries; power of two, at least 2.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-004 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port imem_addr, output, XLEN-2 bits: word address to the combinational instruction ROM, equal to fetch_pc[XLEN-1:2].
REQ-007 SHALL have port imem_rdata, input, XLEN bits: ROM data for imem_addr, valid in the same cycle.
REQ-008 SHALL have port redirect_valid, input, 1 bit: branch or jump taken this cycle.
REQ-009 SHALL have port redirect_pc, input, XLEN bits: redirect target.
REQ-010 SHALL have port out_valid, output, 1 bit: head entry valid toward decode.
REQ-011 SHALL have port out_ready, input, 1 bit: decode accepts the head (decode not stalled).
REQ-012 SHALL have port out_instr, output, XLEN bits: head instruction.
REQ-013 SHALL have port out_pcplus4, output, XLEN bits: head PC+4.
REQ-014 SHALL have port misalign_err, output, 1 bit: one-cycle pulse, redirect_pc[1:0] was nonzero.

Function
REQ-015 SHALL push {imem_rdata, fetch_pc+4} and advance fetch_pc by 4 in any cycle where there is no redirect and either count<DEPTH or a dequeue occurs in the same cycle.
REQ-016 SHALL dequeue the head when out_valid && out_ready && !redirect_valid.
REQ-017 SHALL drive out_valid = (count != 0) from registered state only, with no combinational path from out_ready to out_valid.
REQ-018 SHALL present an instruction at out_* on the cycle after it is fetched, giving one-cycle latency.
REQ-019 SHALL, on a simultaneous push and pop when full, leave count at DEPTH and not lose the entry.
REQ-020 SHALL, on a simultaneous push and pop when count is 1, leave count at 1 with the new entry at the head.
REQ-021 SHALL wrap read and write pointers modulo DEPTH; count width SHALL be clog2(DEPTH)+1.
REQ-022 SHALL, when redirect_valid is high, have priority over push and pop: next cycle count=0, fetch_pc={redirect_pc[XLEN-1:2],2'b00}, and no push occurs that cycle.
REQ-023 SHALL, when redirect_valid is high and redirect_pc[1:0]!=0, pulse misalign_err high for the next cycle only; the aligned address is still used.
REQ-024 SHALL let fetch_pc wrap from 2^XLEN-4 to 0 without error.
REQ-025 SHALL hold the head stable while out_valid && !out_ready.

Reset
REQ-026 SHALL, when rst is high at a clock edge, set fetch_pc=RESET_PC, count=0, both pointers=0, misalign_err=0 and out_valid=0, overriding redirect, push and pop.
REQ-027 SHALL make no push in the reset cycle; the first push of RESET_PC occurs in the first cycle with rst low.
REQ-028 SHALL discard all queued entries when reset is asserted mid-stream.

Configuration
REQ-029 SHALL, with FETCH_QUEUE_BYPASS_EN defined, when count==0, redirect_valid low and out_ready high, drive out_valid=1 and out_instr/out_pcplus4 directly from imem_rdata/fetch_pc+4, consume the word without storing it, and advance fetch_pc, giving zero-cycle latency.
REQ-030 SHALL, with FETCH_QUEUE_BYPASS_EN undefined, have no combinational path from imem_rdata to out_*.

Structure
REQ-031 SHALL place the XLEN default, the RESET_PC default and the entry struct {instr, pcplus4} in shared package fetch_pkg.
REQ-032 SHALL implement entry storage and pointers in sub-module fetch_fifo (parametrised by DEPTH and entry width); fetch_queue SHALL own the PC, redirect and bypass logic.

Verification
REQ-033 Reset, then rst low, out_ready=1, ROM word n = 32'h1000_0000+n -> first out_valid on cycle 2 with out_instr=32'h1000_0000, out_pcplus4=4; one entry per cycle thereafter.
REQ-034 out_ready=0 for 10 cycles, DEPTH=4 -> count saturates at 4; imem_addr holds at 4 while full; releasing out_ready delivers entries 0..3 then 4 with none skipped.
REQ-035 redirect_valid with redirect_pc=32'h0000_0040 while count=3 -> out_valid=0 next cycle; next delivered out_instr is ROM word 16 with out_pcplus4=32'h44.
REQ-036 redirect_pc=32'h0000_0042 -> misalign_err high for exactly one cycle; fetch resumes at 32'h40.
REQ-037 rst asserted mid-stream with count=2 -> next cycle out_valid=0 and imem_addr=RESET_PC>>2.
REQ-038 With FETCH_QUEUE_BYPASS_EN defined and the queue empty, out_ready=1 -> out_instr equals imem_rdata in the same cycle and count stays 0.
